prim_alert_receiver_sync: RTL and testbench

Receiving end of the differential alert protocol, used inside the alert handler with one instance per peripheral alert source. The block decodes the incoming alert_p/n pair and completes each four-phase handshake by driving the ack_p/n pair. It issues in-band pings by toggling ping_p/n and reports three conditions: a real alert, a successful ping response, or a signal-integrity failure on the pair.

---
 rtl/prim_alert_pkg.sv | 26 ++
 rtl/prim_buf.sv | 9 +
 rtl/prim_diff_decode_sync.sv | 53 +++++
 rtl/prim_alert_receiver_sync.sv | 129 ++++++++++++
 tb/tb_prim_alert_receiver_sync.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/prim_alert_pkg.sv
// Shared types for the differential alert protocol: the sender/receiver wire
// bundles, their idle values, and the receiver handshake states.
package prim_alert_pkg;

   typedef struct packed {
      logic alert_p;
      logic alert_n;
   } alert_tx_t;

   typedef struct packed {
      logic ping_p;
      logic ping_n;
      logic ack_p;
      logic ack_n;
   } alert_rx_t;

   localparam alert_rx_t AlertRxReset = '{ping_p: 1'b0, ping_n: 1'b1, ack_p: 1'b0, ack_n: 1'b1};

   typedef enum logic [1:0] {
      Idle      = 2'd0,
      HsAckWait = 2'd1,
      Pause0    = 2'd2,
      Pause1    = 2'd3
   } rx_state_e;

endpackage

// File: rtl/prim_buf.sv
// Single-bit buffer cell; gives each outgoing rx line a distinct, keepable driver.
module prim_buf (
   input  logic in_i,
   output logic out_o
);

   assign out_o = in_i;

endmodule

// File: rtl/prim_diff_decode_sync.sv
// Decodes a differential pair into a registered level and a signal-integrity
// flag, optionally behind a two-flop synchronizer.
module prim_diff_decode_sync #(
   parameter bit AsyncOn = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic diff_pi,
   input  logic diff_ni,
   output logic level_o,
   output logic sigint_o
);

   logic p_s, n_s;
   logic level_q, sigint_q;

   if (AsyncOn) begin : gen_sync
      logic [1:0] p_sync_q, n_sync_q;

      // Synchronizer resets to the idle pair (p=0, n=1) so no false sigint leaks out.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            p_sync_q <= 2'b00;
            n_sync_q <= 2'b11;
         end else begin
            p_sync_q <= {p_sync_q[0], diff_pi};
            n_sync_q <= {n_sync_q[0], diff_ni};
         end
      end

      assign p_s = p_sync_q[1];
      assign n_s = n_sync_q[1];
   end else begin : gen_no_sync
      assign p_s = diff_pi;
      assign n_s = diff_ni;
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         level_q  <= 1'b0;
         sigint_q <= 1'b0;
      end else begin
         level_q  <= p_s;
         sigint_q <= (p_s == n_s);
      end
   end

   assign level_o  = level_q;
   assign sigint_o = sigint_q;

endmodule

// File: rtl/prim_alert_receiver_sync.sv
// Receiver side of the differential alert handshake: acknowledges alerts,
// issues in-band pings and flags integrity errors on the alert pair.
module prim_alert_receiver_sync
   import prim_alert_pkg::*;
#(
   parameter bit AsyncOn = 1'b0
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      ping_req_i,
   output logic      ping_ok_o,
   output logic      alert_o,
   output logic      integ_fail_o,
   output alert_rx_t alert_rx_o,
   input  alert_tx_t alert_tx_i
);

   logic level, sigint;

   prim_diff_decode_sync #(
      .AsyncOn(AsyncOn)
   ) u_decode (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .diff_pi (alert_tx_i.alert_p),
      .diff_ni (alert_tx_i.alert_n),
      .level_o (level),
      .sigint_o(sigint)
   );

   rx_state_e state_q, state_d;
   logic ack_p_q, ack_p_d, ack_n_q;
   logic ping_p_q, ping_p_d, ping_n_q;
   logic ping_pending_q, ping_pending_d;
   logic alert_q, alert_d, ping_ok_q, ping_ok_d, integ_fail_q;
   logic ping_toggle;

   assign ping_toggle = ping_req_i & ~ping_pending_q;
   assign ping_p_d    = ping_p_q ^ ping_toggle;

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d        = state_q;
      ack_p_d        = ack_p_q;
      alert_d        = 1'b0;
      ping_ok_d      = 1'b0;
      ping_pending_d = ping_pending_q | ping_toggle;

      case (state_q)
         Idle: begin
            if (level) begin
               state_d = HsAckWait;
               ack_p_d = 1'b1;
               // A pending ping claims the handshake; a same-edge request is seen next time.
               if (ping_pending_q) begin
                  ping_ok_d      = 1'b1;
                  ping_pending_d = 1'b0;
               end else begin
                  alert_d = 1'b1;
               end
            end
         end
         HsAckWait: begin
            if (!level) begin
               state_d = Pause0;
               ack_p_d = 1'b0;
            end
         end
         Pause0: begin
            state_d = Pause1;
            ack_p_d = 1'b0;
         end
         Pause1: begin
            state_d = Idle;
            ack_p_d = 1'b0;
         end
         default: begin
            state_d = Idle;
            ack_p_d = 1'b0;
         end
      endcase

      if (sigint) begin
         state_d        = Idle;
         ack_p_d        = 1'b0;
         ping_pending_d = 1'b0;
         alert_d        = 1'b0;
         ping_ok_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q        <= Idle;
         ack_p_q        <= AlertRxReset.ack_p;
         ack_n_q        <= AlertRxReset.ack_n;
         ping_p_q       <= AlertRxReset.ping_p;
         ping_n_q       <= AlertRxReset.ping_n;
         ping_pending_q <= 1'b0;
         alert_q        <= 1'b0;
         ping_ok_q      <= 1'b0;
         integ_fail_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         ack_p_q        <= ack_p_d;
         ack_n_q        <= ~ack_p_d;
         ping_p_q       <= ping_p_d;
         ping_n_q       <= ~ping_p_d;
         ping_pending_q <= ping_pending_d;
         alert_q        <= alert_d;
         ping_ok_q      <= ping_ok_d;
         integ_fail_q   <= sigint;
      end
   end

   logic ping_p_buf, ping_n_buf, ack_p_buf, ack_n_buf;

   prim_buf u_buf_ping_p (.in_i(ping_p_q), .out_o(ping_p_buf));
   prim_buf u_buf_ping_n (.in_i(ping_n_q), .out_o(ping_n_buf));
   prim_buf u_buf_ack_p  (.in_i(ack_p_q),  .out_o(ack_p_buf));
   prim_buf u_buf_ack_n  (.in_i(ack_n_q),  .out_o(ack_n_buf));

   assign alert_rx_o   = '{ping_p: ping_p_buf, ping_n: ping_n_buf, ack_p: ack_p_buf, ack_n: ack_n_buf};
   assign alert_o      = alert_q;
   assign ping_ok_o    = ping_ok_q;
   assign integ_fail_o = integ_fail_q;

endmodule

// File: tb/tb_prim_alert_receiver_sync.sv
// Drives both synchronizer variants with the same stimulus and checks them
// against a cycle-level reference model through a pulse scoreboard.
module tb_prim_alert_receiver_sync;
   import prim_alert_pkg::*;

   localparam int KindAlert  = 1;
   localparam int KindPingOk = 2;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic      clk = 1'b0;
   logic      rst_ni;
   logic      ping_req;
   alert_tx_t tx;

   logic      ping_ok_s [2];
   logic      alert_s   [2];
   logic      integ_s   [2];
   alert_rx_t rx_s      [2];

   prim_alert_receiver_sync #(.AsyncOn(1'b0)) u_dut0 (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .ping_req_i  (ping_req),
      .ping_ok_o   (ping_ok_s[0]),
      .alert_o     (alert_s[0]),
      .integ_fail_o(integ_s[0]),
      .alert_rx_o  (rx_s[0]),
      .alert_tx_i  (tx)
   );

   prim_alert_receiver_sync #(.AsyncOn(1'b1)) u_dut1 (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .ping_req_i  (ping_req),
      .ping_ok_o   (ping_ok_s[1]),
      .alert_o     (alert_s[1]),
      .integ_fail_o(integ_s[1]),
      .alert_rx_o  (rx_s[1]),
      .alert_tx_i  (tx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_seen [2][3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: a delay line for the input samples, a busy flag for the
   // acknowledge and a cool-down count for the quiet period after release.
   bit        m_ack   [2];
   int        m_cool  [2];
   bit        m_pend  [2];
   bit        m_ping  [2];
   bit        m_integ [2];
   alert_tx_t m_hist  [2][4];
   ev_t       sb      [2][$];

   task automatic model_step(input int d);
      alert_tx_t s;
      bit lv, sg, pend_old;
      if (!rst_ni) begin
         m_ack[d] = 0; m_cool[d] = 0; m_pend[d] = 0; m_ping[d] = 0; m_integ[d] = 0;
         for (int i = 0; i < 4; i++) m_hist[d][i] = '{alert_p: 1'b0, alert_n: 1'b1};
         return;
      end
      for (int i = 3; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
      m_hist[d][0] = tx;
      s  = m_hist[d][(d == 1) ? 3 : 1];
      lv = s.alert_p;
      sg = (s.alert_p == s.alert_n);
      pend_old = m_pend[d];
      if (ping_req && !pend_old) begin
         m_ping[d] = ~m_ping[d];
         m_pend[d] = 1;
      end
      m_integ[d] = sg;
      if (sg) begin
         m_ack[d] = 0; m_cool[d] = 0; m_pend[d] = 0;
      end else if (m_cool[d] > 0) begin
         m_cool[d]--;
      end else if (m_ack[d]) begin
         if (!lv) begin
            m_ack[d] = 0; m_cool[d] = 2;
         end
      end else if (lv) begin
         m_ack[d] = 1;
         if (pend_old) begin
            m_pend[d] = 0;
            sb[d].push_back('{kind: KindPingOk, cyc: cyc});
         end else begin
            sb[d].push_back('{kind: KindAlert, cyc: cyc});
         end
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0);
      model_step(1);
   end

   // Monitor: level outputs every cycle, pulses matched against the scoreboard.
   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int d = 0; d < 2; d++) begin
            alert_rx_t e;
            int kind;
            ev_t ev;
            e = '{ping_p: m_ping[d], ping_n: ~m_ping[d], ack_p: m_ack[d], ack_n: ~m_ack[d]};
            check($sformatf("rx_lines dut%0d", d), 32'(rx_s[d]), 32'(e));
            check($sformatf("integ_fail dut%0d", d), 32'(integ_s[d]), 32'(m_integ[d]));
            while (sb[d].size() > 0 && sb[d][0].cyc < cyc) begin
               ev = sb[d].pop_front();
               check($sformatf("missed_pulse dut%0d", d), 32'd0, 32'(ev.kind));
            end
            kind = (alert_s[d] ? KindAlert : 0) + (ping_ok_s[d] ? KindPingOk : 0);
            if (kind != 0) begin
               if (sb[d].size() == 0) begin
                  check($sformatf("unexpected_pulse dut%0d", d), 32'(kind), 32'd0);
               end else begin
                  ev = sb[d].pop_front();
                  check($sformatf("pulse_kind dut%0d", d), 32'(kind), 32'(ev.kind));
                  check($sformatf("pulse_cycle dut%0d", d), 32'(cyc), 32'(ev.cyc));
                  if (kind <= 2) n_seen[d][kind]++;
               end
            end
         end
      end
   end

   task automatic drive(input logic p, input logic n, input logic req, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         tx.alert_p = p;
         tx.alert_n = n;
         ping_req   = (i == 0) ? req : 1'b0;
      end
   endtask

   initial begin
      rst_ni   = 1'b0;
      ping_req = 1'b0;
      tx       = '{alert_p: 1'b0, alert_n: 1'b1};
      for (int d = 0; d < 2; d++) for (int k = 0; k < 3; k++) n_seen[d][k] = 0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;

      // Plain alert handshake.
      drive(1, 0, 0, 5);
      drive(0, 1, 0, 12);
      // Ping followed by a sender handshake.
      drive(0, 1, 1, 2);
      drive(1, 0, 0, 5);
      drive(0, 1, 0, 10);
      // Second ping request while pending is ignored; then ping_ok, then an alert.
      drive(0, 1, 1, 2);
      drive(0, 1, 1, 2);
      drive(1, 0, 0, 6);
      drive(0, 1, 0, 10);
      drive(1, 0, 0, 6);
      drive(0, 1, 0, 10);
      // Integrity failure in the middle of a handshake.
      drive(1, 0, 0, 5);
      drive(1, 1, 0, 4);
      drive(0, 1, 0, 10);
      // Sender toggling both lines together.
      drive(0, 0, 0, 2);
      drive(1, 1, 0, 2);
      drive(0, 0, 0, 2);
      drive(0, 1, 0, 8);
      // Reset pulse during HsAckWait.
      drive(1, 0, 1, 6);
      @(negedge clk);
      rst_ni = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      drive(0, 1, 0, 10);

      // Randomized traffic.
      for (int seg = 0; seg < 800; seg++) begin
         int r, len;
         logic p, n;
         r = $urandom_range(99);
         if (r < 88) begin
            p = 1'($urandom_range(1)); n = ~p; len = $urandom_range(10, 1);
         end else begin
            p = 1'($urandom_range(1)); n = p; len = $urandom_range(4, 1);
         end
         for (int i = 0; i < len; i++) begin
            @(negedge clk);
            tx.alert_p = p;
            tx.alert_n = n;
            ping_req   = ($urandom_range(99) < 15);
            rst_ni     = ($urandom_range(999) >= 4);
         end
      end
      rst_ni = 1'b1;
      drive(0, 1, 0, 12);

      for (int d = 0; d < 2; d++) begin
         check($sformatf("scoreboard_drained dut%0d", d), 32'(sb[d].size()), 32'd0);
         check($sformatf("alerts_observed dut%0d", d), 32'(n_seen[d][KindAlert] > 0), 32'd1);
         check($sformatf("ping_oks_observed dut%0d", d), 32'(n_seen[d][KindPingOk] > 0), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
